// File: rtl/wishbone_arbiter_rr.sv
`default_nettype none
// wishbone_arbiter_rr: round-robin arbiter sharing one Wishbone B4 Classic device among N_CTRL controllers.
// Optional macro WB_ARB_TIMEOUT_EN adds a stall timeout that force-releases the grant and pulses c_err_o.
module wishbone_arbiter_rr #(
  parameter int N_CTRL         = 4,
  parameter int ADR_WIDTH      = 8,
  parameter int DAT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_CTRL-1:0]           c_cyc_i,
  input  logic [N_CTRL-1:0]           c_stb_i,
  input  logic [N_CTRL-1:0]           c_we_i,
  input  logic [N_CTRL*ADR_WIDTH-1:0] c_adr_i,
  input  logic [N_CTRL*DAT_WIDTH-1:0] c_dat_i,
  output logic [DAT_WIDTH-1:0]        c_dat_o,
  output logic [N_CTRL-1:0]           c_ack_o,
  output logic [N_CTRL-1:0]           c_err_o,
  output logic [N_CTRL-1:0]           gnt_o,
  output logic                        d_cyc_o,
  output logic                        d_stb_o,
  output logic                        d_we_o,
  output logic [ADR_WIDTH-1:0]        d_adr_o,
  output logic [DAT_WIDTH-1:0]        d_dat_o,
  input  logic [DAT_WIDTH-1:0]        d_dat_i,
  input  logic                        d_ack_i
);
  localparam int IW = $clog2(N_CTRL);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [N_CTRL-1:0]    gnt_nxt;
  logic [IW-1:0]        owner, owner_nxt, owner_inc;
  logic [IW-1:0]        ptr, ptr_nxt, winner;
  logic [IW:0]          cand;
  logic                 any_req, busy, timeout;
  logic [ADR_WIDTH-1:0] adr_arr [N_CTRL];
  logic [DAT_WIDTH-1:0] dat_arr [N_CTRL];

  for (genvar i = 0; i < N_CTRL; i++) begin : g_slice
    assign adr_arr[i] = c_adr_i[i*ADR_WIDTH +: ADR_WIDTH];
    assign dat_arr[i] = c_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
  end

  // Scan downwards so the last hit is the smallest offset from ptr, i.e. the round-robin winner.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    cand    = '0;
    for (int k = N_CTRL - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_CTRL)) cand = cand - (IW+1)'(N_CTRL);
      if (c_cyc_i[cand[IW-1:0]]) begin
        winner  = cand[IW-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign owner_inc = (owner == IW'(N_CTRL - 1)) ? '0 : owner + IW'(1);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt_o;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt       = GRANT;
          owner_nxt       = winner;
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
        end
      end
      GRANT: begin
        if (!c_cyc_i[owner] || timeout) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = owner_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt_o <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt_o <= gnt_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Datapath is purely combinational off the registered grant, so an async reset clears it at once.
  assign busy    = (state == GRANT);
  assign d_cyc_o = busy & c_cyc_i[owner];
  assign d_stb_o = busy & c_stb_i[owner];
  assign d_we_o  = busy & c_we_i[owner];
  assign d_adr_o = busy ? adr_arr[owner] : '0;
  assign d_dat_o = busy ? dat_arr[owner] : '0;
  assign c_ack_o = gnt_o & {N_CTRL{d_ack_i}};
  assign c_dat_o = d_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0]     stall_cnt;
  logic [N_CTRL-1:0] err_q;
  logic              stall;

  assign stall   = d_cyc_o & d_stb_o & ~d_ack_i;
  assign timeout = stall && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      err_q     <= '0;
    end else begin
      if (!d_cyc_o || d_ack_i || timeout) stall_cnt <= '0;
      else if (stall)                     stall_cnt <= stall_cnt + CW'(1);
      err_q <= timeout ? gnt_o : '0;
    end
  end

  assign c_err_o = err_q;
`else
  assign timeout = 1'b0;
  assign c_err_o = '0;
`endif

endmodule
`default_nettype wire

// File: doc/wishbone_arbiter_rr.md
Name: wishbone_arbiter_rr

Overview:
- Round-robin arbiter that shares one Wishbone B4 Classic device between N_CTRL controllers.
- Grants the bus to one controller at a time and holds the grant for that controller's whole cycle (cyc high).
- Muxes the granted controller's signals to the device side and routes the device's ack/data back.
- Sits between CPU, DMA and debug controllers and a single wishbone_classic device port.

Parameters:
- N_CTRL, 4, number of controllers; legal range 2..16
- ADR_WIDTH, 8, address width
- DAT_WIDTH, 8, data width
- TIMEOUT_CYCLES, 64, stall limit; used only when WB_ARB_TIMEOUT_EN is defined; must be >= 2

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- c_cyc_i  in  N_CTRL  per-controller cyc
- c_stb_i  in  N_CTRL  per-controller stb
- c_we_i  in  N_CTRL  per-controller we
- c_adr_i  in  N_CTRL*ADR_WIDTH  packed addresses; controller i occupies slice [i*ADR_WIDTH +: ADR_WIDTH]
- c_dat_i  in  N_CTRL*DAT_WIDTH  packed write data; same slicing rule
- c_dat_o  out  DAT_WIDTH  read data, broadcast to all controllers
- c_ack_o  out  N_CTRL  per-controller ack
- c_err_o  out  N_CTRL  per-controller timeout error
- gnt_o  out  N_CTRL  one-hot grant (all zero when idle)
- d_cyc_o, d_stb_o, d_we_o  out  1 each  device-side cyc, stb, we
- d_adr_o  out  ADR_WIDTH  device address
- d_dat_o  out  DAT_WIDTH  device write data
- d_dat_i  in  DAT_WIDTH  device read data
- d_ack_i  in  1  device ack

Behaviour:
- Reset:
  - rst_i is asynchronous and active-high.
  - State returns to IDLE, gnt_o=0 and the priority pointer ptr=0.
  - All of d_cyc_o, d_stb_o, d_we_o, c_ack_o and c_err_o go to 0 immediately, without waiting for a clock edge.
  - d_adr_o and d_dat_o are 0 while gnt_o=0.
- State machine, states IDLE and GRANT:
  - IDLE: on a clock edge where any c_cyc_i bit is high, the winner g is the first index >= ptr with c_cyc_i high, searching with wrap-around. gnt_o <= onehot(g), then go to GRANT.
  - IDLE with no c_cyc_i bit high: stay in IDLE.
  - GRANT: stay while c_cyc_i[g]=1. On the clock edge where c_cyc_i[g]=0 is sampled: gnt_o <= 0, ptr <= (g+1) mod N_CTRL, go to IDLE.
- Latency:
  - A request sampled at edge k produces a grant and device cyc/stb in the cycle after edge k.
  - There is exactly one IDLE cycle between consecutive grants, even when other requests are pending at release.
- Datapath (combinational from the registered grant):
  - d_cyc_o = c_cyc_i[g] and d_stb_o = c_stb_i[g], both qualified by the grant.
  - d_we_o, d_adr_o and d_dat_o come from slice g.
  - c_ack_o[g] = d_ack_i; every other bit of c_ack_o is 0.
  - c_dat_o = d_dat_i at all times.
- d_ack_i is ignored while in IDLE.
- Non-granted controllers see no ack and must hold their signals stable until granted.
- Multiple back-to-back stb transfers within one cyc stay with the same controller; there is no pre-emption.
- A controller dropping cyc while it is not granted has no effect.
- Fairness: with all N_CTRL controllers continuously requesting, grants rotate 0,1,2,...,N_CTRL-1,0,...

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter, sized to hold TIMEOUT_CYCLES, counts cycles in GRANT with d_stb_o=1 and d_ack_i=0.
  - The counter clears on d_ack_i, on release, and on reset.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack, c_err_o[g] pulses high for one cycle at the next edge, the grant is forcibly released, ptr advances and the state goes to IDLE.
  - d_cyc_o drops in the same cycle that c_err_o is high.
  - A controller that still holds cyc re-enters arbitration normally.
- When not defined:
  - No counter is built and c_err_o is tied to 0.
  - Grants are held indefinitely.

Test Plan:
- Reset held, all c_cyc_i=4'b1111 -> gnt_o=0 and d_cyc_o=0. Release reset -> gnt_o=4'b0001 one cycle later.
- Only controller 2 requests a write (adr=8'h5A, dat=8'hC3) and the device acks after 3 cycles -> d_adr_o=8'h5A, d_dat_o=8'hC3, d_we_o=1; c_ack_o=4'b0100 for one cycle; gnt_o=0 one cycle after c_cyc_i[2] falls.
- All four controllers request continuously, each doing one transfer per cyc -> grant sequence 0,1,2,3,0 with exactly one idle cycle between grants.
- Controller 1 is granted and does 3 back-to-back stb reads while controller 0 also requests -> controller 1 keeps the grant for all 3 acks; controller 0 is granted next; device read data 8'hA5 appears on c_dat_o.
- rst_i is asserted mid-transfer, asynchronously between edges -> d_cyc_o and gnt_o drop before the next edge; after reset, ptr=0 so controller 0 wins if it is requesting.
- With WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, and the device never acking -> c_err_o[g]=1 for one cycle after 8 stalled cycles; gnt_o=0 and the next requester is granted. Without the macro -> the grant is held for more than 100 cycles and c_err_o stays 0.
